// File: rtl/vga_timing_pkg.sv
// Raster constants, lock-state encoding and counter helpers shared by the VGA
// generator and the sink-side sync decoder.
package vga_timing_pkg;

    localparam int   H_TOTAL  = 800;
    localparam int   V_TOTAL  = 525;
    localparam int   H_START  = 144;
    localparam int   V_START  = 35;
    localparam int   H_ACTIVE = 640;
    localparam int   V_ACTIVE = 480;
    localparam logic SYNC_POL = 1'b0;

    localparam int         CNT_W   = 10;
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    // Counters stick at full scale so an over-long line can never wrap back
    // into a plausible count.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Polarity-aware sync leading-edge detector; the previous level only advances
// on pixel strobes so held pixels never manufacture edges.
module vga_sync_edge #(
    parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pix_en,
    input  logic i_sync,
    output logic o_edge
);

    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= ~SYNC_POL;
        end else if (i_pix_en) begin
            r_prev <= i_sync;
        end
    end

    assign o_edge = i_pix_en && (i_sync == SYNC_POL) && (r_prev != SYNC_POL);

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA sink decoder: recovers pixel coordinates from HS/VS, checks line and
// frame timing against the raster, and keeps a per-frame RGB checksum.
module vga_sync_decoder #(
    parameter int   H_TOTAL  = vga_timing_pkg::H_TOTAL,
    parameter int   V_TOTAL  = vga_timing_pkg::V_TOTAL,
    parameter int   H_START  = vga_timing_pkg::H_START,
    parameter int   V_START  = vga_timing_pkg::V_START,
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_en,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [7:0]  i_rgb,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic        o_active,
    output logic        o_locked,
    output logic        o_sync_err,
    output logic        o_frame_done,
    output logic [15:0] o_frame_sum
);

    import vga_timing_pkg::*;

    localparam logic [10:0] L_H_TOTAL = 11'(H_TOTAL);
    localparam logic [10:0] L_V_TOTAL = 11'(V_TOTAL);
    localparam logic [10:0] L_H_START = 11'(H_START);
    localparam logic [10:0] L_V_START = 11'(V_START);
    localparam logic [10:0] L_H_END   = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] L_V_END   = 11'(V_START + V_ACTIVE);
    localparam logic [9:0]  L_X_OFS   = 10'(H_START);
    localparam logic [9:0]  L_Y_OFS   = 10'(V_START);

    logic        w_hsEdge;
    logic        w_vsEdge;
    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    logic [9:0]  w_hcntNext;
    logic [9:0]  w_vcntNext;
    logic        r_linesOk;
    logic        w_lineGood;
    logic        w_allLinesGood;
    logic        w_frameGood;
    logic        w_activeNext;
    logic [9:0]  w_xNext;
    logic [9:0]  w_yNext;
    logic        r_active;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [15:0] r_sum16;
    logic [15:0] r_frameSum;
    logic        r_syncErr;
    logic        r_frameDone;
    lock_state_t r_state;
    lock_state_t w_stateNext;
    logic        w_syncErrNext;
    logic        w_frameDoneNext;

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hsEdge (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_pix_en (i_pix_en),
        .i_sync   (i_hs),
        .o_edge   (w_hsEdge)
    );

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vsEdge (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_pix_en (i_pix_en),
        .i_sync   (i_vs),
        .o_edge   (w_vsEdge)
    );

    // VS reset wins over the HS line increment so a coincident pair lands on (0,0).
    always_comb begin
        w_hcntNext = r_hcnt;
        w_vcntNext = r_vcnt;
        if (i_pix_en) begin
            if (w_hsEdge) begin
                w_hcntNext = '0;
                w_vcntNext = sat_inc(r_vcnt);
            end else begin
                w_hcntNext = sat_inc(r_hcnt);
            end
            if (w_vsEdge) begin
                w_vcntNext = '0;
            end
        end
    end

    assign w_lineGood     = ({1'b0, r_hcnt} + 11'd1) == L_H_TOTAL;
    assign w_allLinesGood = r_linesOk && (!w_hsEdge || w_lineGood);
    assign w_frameGood    = w_vsEdge && w_hsEdge && w_allLinesGood &&
                            (({1'b0, r_vcnt} + 11'd1) == L_V_TOTAL);

    assign w_activeNext = ({1'b0, w_hcntNext} >= L_H_START) &&
                          ({1'b0, w_hcntNext} <  L_H_END)   &&
                          ({1'b0, w_vcntNext} >= L_V_START) &&
                          ({1'b0, w_vcntNext} <  L_V_END);
    assign w_xNext = w_activeNext ? (w_hcntNext - L_X_OFS) : '0;
    assign w_yNext = w_activeNext ? (w_vcntNext - L_Y_OFS) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_linesOk <= 1'b1;
            r_active  <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
        end else if (i_pix_en) begin
            r_hcnt   <= w_hcntNext;
            r_vcnt   <= w_vcntNext;
            r_active <= w_activeNext;
            r_x      <= w_xNext;
            r_y      <= w_yNext;
            if (w_vsEdge) begin
                r_linesOk <= 1'b1;
            end else if (w_hsEdge) begin
                r_linesOk <= r_linesOk && w_lineGood;
            end
        end
    end

    // The running sum restarts at every frame boundary regardless of lock state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum16    <= '0;
            r_frameSum <= '0;
        end else begin
            if (i_pix_en) begin
                if (w_vsEdge) begin
                    r_sum16 <= '0;
                end else if (w_activeNext) begin
                    r_sum16 <= r_sum16 + {8'd0, i_rgb};
                end
            end
            if (w_frameDoneNext) begin
                r_frameSum <= r_sum16;
            end
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_syncErrNext   = 1'b0;
        w_frameDoneNext = 1'b0;
        if (w_vsEdge) begin
            case (r_state)
                SEARCH: w_stateNext = CHECK;
                CHECK: begin
                    if (w_frameGood) begin
                        w_stateNext = LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_frameGood) begin
                        w_frameDoneNext = 1'b1;
                    end else begin
                        w_syncErrNext = 1'b1;
                        w_stateNext   = SEARCH;
                    end
                end
                default: w_stateNext = SEARCH;
            endcase
        end else if (w_hsEdge && !w_lineGood && (r_state == LOCKED)) begin
            w_syncErrNext = 1'b1;
            w_stateNext   = SEARCH;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= SEARCH;
            r_syncErr   <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_syncErr   <= w_syncErrNext;
            r_frameDone <= w_frameDoneNext;
        end
    end

    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_active     = r_active;
    assign o_locked     = (r_state == LOCKED);
    assign o_sync_err   = r_syncErr;
    assign o_frame_done = r_frameDone;
    assign o_frame_sum  = r_frameSum;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench: a nominal-size decoder for coordinate boundaries and a
// reduced-raster decoder for lock, error, checksum and reset behaviour.
module tb_vga_sync_decoder;

   localparam int T_HT    = 40;
   localparam int T_HSYNC = 4;
   localparam int T_HS    = 6;
   localparam int T_HA    = 32;
   localparam int T_VT    = 20;
   localparam int T_VSYNC = 2;
   localparam int T_VS    = 3;
   localparam int T_VA    = 16;

   logic        clk = 1'b0;
   logic        rstN;

   logic        enS, hsS, vsS;
   logic [7:0]  rgbS;
   logic [9:0]  xS, yS;
   logic        activeS, lockedS, syncErrS, frameDoneS;
   logic [15:0] frameSumS;

   logic        enN, hsN, vsN;
   logic [7:0]  rgbN;
   logic [9:0]  xN, yN;
   logic        activeN, lockedN, syncErrN, frameDoneN;
   logic [15:0] frameSumN;

   int testsRun = 0;
   int testsFailed = 0;

   int frameIdx, curLine, curPix, cycleCnt;
   int seCount, seFrame, seLine, sePix, lockedAtErr;
   int fdCount, fdFrame, lockRiseFrame, lockRiseCycle;
   int bothCount, badFallCount;
   logic [15:0] fdSum;
   logic        prevLocked;
   logic        checkCoords;
   logic        toggleMode;
   logic [7:0]  rgbVal;
   logic [9:0]  expX, expY;
   logic        expAct;

   always #5 clk = ~clk;

   vga_sync_decoder #(
      .H_TOTAL(T_HT), .V_TOTAL(T_VT), .H_START(T_HS), .V_START(T_VS),
      .H_ACTIVE(T_HA), .V_ACTIVE(T_VA), .SYNC_POL(1'b0)
   ) dutSmall (
      .i_clk(clk), .i_rst_n(rstN), .i_pix_en(enS), .i_hs(hsS), .i_vs(vsS),
      .i_rgb(rgbS), .o_x(xS), .o_y(yS), .o_active(activeS), .o_locked(lockedS),
      .o_sync_err(syncErrS), .o_frame_done(frameDoneS), .o_frame_sum(frameSumS)
   );

   vga_sync_decoder dutNom (
      .i_clk(clk), .i_rst_n(rstN), .i_pix_en(enN), .i_hs(hsN), .i_vs(vsN),
      .i_rgb(rgbN), .o_x(xN), .o_y(yN), .o_active(activeN), .o_locked(lockedN),
      .o_sync_err(syncErrN), .o_frame_done(frameDoneN), .o_frame_sum(frameSumN)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " small x"},         32'(xS), 0);
      checkOutput({tag, " small y"},         32'(yS), 0);
      checkOutput({tag, " small active"},    32'(activeS), 0);
      checkOutput({tag, " small locked"},    32'(lockedS), 0);
      checkOutput({tag, " small sync_err"},  32'(syncErrS), 0);
      checkOutput({tag, " small frame_done"},32'(frameDoneS), 0);
      checkOutput({tag, " small frame_sum"}, 32'(frameSumS), 0);
      checkOutput({tag, " nom locked"},      32'(lockedN), 0);
      checkOutput({tag, " nom active"},      32'(activeN), 0);
   endtask

   // One clock on the reduced decoder; outputs are sampled 1 time unit after the edge.
   task automatic applyStimulus(input logic hs, input logic vs, input logic [7:0] rgb,
                                input logic en);
      hsS = hs; vsS = vs; rgbS = rgb; enS = en;
      @(posedge clk); #1;
      cycleCnt++;
      if (checkCoords) begin
         checkOutput("pixel x", 32'(xS), 32'(expX));
         checkOutput("pixel y", 32'(yS), 32'(expY));
         checkOutput("pixel active", 32'(activeS), 32'(expAct));
      end
      if (syncErrS) begin
         seCount++; seFrame = frameIdx; seLine = curLine; sePix = curPix;
         lockedAtErr = int'(lockedS);
      end
      if (frameDoneS) begin
         fdCount++; fdFrame = frameIdx; fdSum = frameSumS;
      end
      if (syncErrS && frameDoneS) bothCount++;
      if (lockedS && !prevLocked) begin
         lockRiseFrame = frameIdx; lockRiseCycle = cycleCnt;
      end
      if (!lockedS && prevLocked && !syncErrS) badFallCount++;
      prevLocked = lockedS;
   endtask

   task automatic drivePix(input int l, input int p);
      logic hs, vs, act;
      hs  = (p < T_HSYNC) ? 1'b0 : 1'b1;
      vs  = (l < T_VSYNC) ? 1'b0 : 1'b1;
      act = (p >= T_HS) && (p < T_HS + T_HA) && (l >= T_VS) && (l < T_VS + T_VA);
      curLine = l; curPix = p;
      expAct = act;
      expX = act ? 10'(p - T_HS) : 10'd0;
      expY = act ? 10'(l - T_VS) : 10'd0;
      applyStimulus(hs, vs, act ? rgbVal : 8'h00, 1'b1);
      if (toggleMode) applyStimulus(hs, vs, act ? rgbVal : 8'h00, 1'b0);
   endtask

   task automatic driveFrame(input int nLines, input int shortLine);
      frameIdx++;
      checkCoords = 1'b1;
      for (int l = 0; l < nLines; l++) begin
         for (int p = 0; p < ((l == shortLine) ? T_HT - 1 : T_HT); p++) drivePix(l, p);
      end
   endtask

   task automatic stepNom(input logic hs, input logic vs, input int n);
      for (int i = 0; i < n; i++) begin
         hsN = hs; vsN = vs; rgbN = 8'h01; enN = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic clearEvents();
      frameIdx = 0; cycleCnt = 0;
      seCount = 0; seFrame = -1; seLine = -1; sePix = -1; lockedAtErr = -1;
      fdCount = 0; fdFrame = -1; fdSum = 16'h0;
      lockRiseFrame = -1; lockRiseCycle = -1;
   endtask

   task automatic doReset();
      rstN = 1'b0;
      enS = 1'b0; hsS = 1'b1; vsS = 1'b1; rgbS = 8'h00;
      enN = 1'b0; hsN = 1'b1; vsN = 1'b1; rgbN = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;
      prevLocked = 1'b0;
      checkCoords = 1'b0;
   endtask

   initial begin
      bothCount = 0; badFallCount = 0; prevLocked = 1'b0;
      checkCoords = 1'b0; toggleMode = 1'b0; rgbVal = 8'h01;
      expX = '0; expY = '0; expAct = 1'b0;
      clearEvents();
      rstN = 1'b0;
      enS = 1'b0; hsS = 1'b1; vsS = 1'b1; rgbS = 8'h00;
      enN = 1'b0; hsN = 1'b1; vsN = 1'b1; rgbN = 8'h00;
      #1;
      checkResetState("reset");
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;

      // Nominal-raster coordinates, reached with short lines since no lock is needed.
      stepNom(1'b0, 1'b0, 1);
      for (int i = 0; i < 34; i++) begin stepNom(1'b1, 1'b1, 1); stepNom(1'b0, 1'b1, 1); end
      stepNom(1'b1, 1'b1, 144);
      checkOutput("nom row34 h144 active", 32'(activeN), 0);
      stepNom(1'b0, 1'b1, 1);
      stepNom(1'b1, 1'b1, 143);
      checkOutput("nom h143 active", 32'(activeN), 0);
      checkOutput("nom h143 x", 32'(xN), 0);
      stepNom(1'b1, 1'b1, 1);
      checkOutput("nom first x", 32'(xN), 0);
      checkOutput("nom first y", 32'(yN), 0);
      checkOutput("nom first active", 32'(activeN), 1);
      stepNom(1'b1, 1'b1, 1);
      checkOutput("nom h145 x", 32'(xN), 1);
      for (int i = 0; i < 479; i++) begin stepNom(1'b1, 1'b1, 1); stepNom(1'b0, 1'b1, 1); end
      stepNom(1'b1, 1'b1, 783);
      checkOutput("nom last x", 32'(xN), 639);
      checkOutput("nom last y", 32'(yN), 479);
      checkOutput("nom last active", 32'(activeN), 1);
      stepNom(1'b1, 1'b1, 1);
      checkOutput("nom h784 active", 32'(activeN), 0);
      checkOutput("nom h784 x", 32'(xN), 0);
      checkOutput("nom h784 y", 32'(yN), 0);
      stepNom(1'b0, 1'b1, 1);
      stepNom(1'b1, 1'b1, 144);
      checkOutput("nom row515 active", 32'(activeN), 0);
      checkOutput("nom locked", 32'(lockedN), 0);
      checkOutput("nom sync_err", 32'(syncErrN), 0);

      // Nominal reduced raster from reset: lock on the 2nd VS edge, checksum on the 3rd.
      doReset();
      clearEvents();
      rgbVal = 8'h01;
      repeat (3) driveFrame(T_VT, -1);
      checkOutput("lock frame", lockRiseFrame, 2);
      checkOutput("lock cycle", lockRiseCycle, 801);
      checkOutput("fd count", fdCount, 1);
      checkOutput("fd frame", fdFrame, 3);
      checkOutput("fd sum", 32'(fdSum), 32'h0200);
      checkOutput("sync_err count", seCount, 0);
      checkOutput("locked after 3", 32'(lockedS), 1);

      // Checksum wraps modulo 2^16: 512 * 0xC0 = 0x18000.
      clearEvents();
      rgbVal = 8'hC0;
      repeat (2) driveFrame(T_VT, -1);
      checkOutput("wrap fd count", fdCount, 2);
      checkOutput("wrap fd sum", 32'(fdSum), 32'h8000);
      rgbVal = 8'h01;

      // Short line while locked, then re-lock two VS edges later.
      clearEvents();
      driveFrame(T_VT, 5);
      driveFrame(T_VT, -1);
      driveFrame(T_VT, -1);
      checkOutput("short se count", seCount, 1);
      checkOutput("short se frame", seFrame, 1);
      checkOutput("short se line", seLine, 6);
      checkOutput("short se pix", sePix, 0);
      checkOutput("short locked at err", lockedAtErr, 0);
      checkOutput("short fd count", fdCount, 1);
      checkOutput("short relock frame", lockRiseFrame, 3);

      // Frame one line short while locked.
      clearEvents();
      driveFrame(T_VT - 1, -1);
      driveFrame(T_VT, -1);
      checkOutput("vshort se count", seCount, 1);
      checkOutput("vshort se frame", seFrame, 2);
      checkOutput("vshort se line", seLine, 0);
      checkOutput("vshort se pix", sePix, 0);
      checkOutput("vshort fd count", fdCount, 1);
      checkOutput("vshort fd frame", fdFrame, 1);
      checkOutput("vshort locked", 32'(lockedS), 0);
      repeat (2) driveFrame(T_VT, -1);
      checkOutput("vshort relock frame", lockRiseFrame, 4);

      // pix_en alternating: same lock point and sum at twice the clock count.
      doReset();
      clearEvents();
      toggleMode = 1'b1;
      repeat (3) driveFrame(T_VT, -1);
      checkOutput("toggle lock frame", lockRiseFrame, 2);
      checkOutput("toggle lock cycle", lockRiseCycle, 1601);
      checkOutput("toggle fd count", fdCount, 1);
      checkOutput("toggle fd frame", fdFrame, 3);
      checkOutput("toggle fd sum", 32'(fdSum), 32'h0200);
      checkOutput("toggle se count", seCount, 0);
      toggleMode = 1'b0;

      // Reset mid-line while locked, then the first frame_done needs the 3rd VS edge.
      frameIdx++;
      checkCoords = 1'b1;
      for (int l = 0; l < 10; l++) for (int p = 0; p < T_HT; p++) drivePix(l, p);
      for (int p = 0; p < 17; p++) drivePix(10, p);
      checkOutput("pre-reset locked", 32'(lockedS), 1);
      rstN = 1'b0;
      #1;
      checkResetState("midline reset");
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;
      prevLocked = 1'b0;
      clearEvents();
      checkCoords = 1'b0;
      for (int p = 17; p < T_HT; p++) drivePix(10, p);
      for (int l = 11; l < T_VT; l++) for (int p = 0; p < T_HT; p++) drivePix(l, p);
      repeat (3) driveFrame(T_VT, -1);
      checkOutput("post-reset lock frame", lockRiseFrame, 2);
      checkOutput("post-reset fd count", fdCount, 1);
      checkOutput("post-reset fd frame", fdFrame, 3);
      checkOutput("post-reset fd sum", 32'(fdSum), 32'h0200);
      checkOutput("post-reset se count", seCount, 0);

      checkOutput("pulse exclusivity", bothCount, 0);
      checkOutput("lock fall without sync_err", badFallCount, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
